// File: rtl/inst_fetch_pkg.sv
// Shared CPU-wide constants and fetch-state encodings used by the
// instruction-fetch front end.
package cpu_defs;

    localparam int ROM_AW = 10;
    localparam int DATA_W = 32;
    localparam int PC_W   = 32;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam int          PC_STEP  = 4;

    typedef enum logic {
        FETCH_WAIT = 1'b0,
        FETCH_RUN  = 1'b1
    } fetch_state_e;

endpackage : cpu_defs

// File: rtl/inst_fetch_if.sv
// Bundle of the program-ROM request/response bus and the fetch-to-decode
// handshake. The fetch unit is the master; the ROM plus decode side is the slave.
interface inst_fetch_if #(
    parameter int ROM_AW = cpu_defs::ROM_AW,
    parameter int DATA_W = cpu_defs::DATA_W,
    parameter int PC_W   = cpu_defs::PC_W
);

    logic              stall_i;
    logic              branch_i;
    logic [PC_W-1:0]   branch_target_i;

    logic              rom_ce_o;
    logic [ROM_AW-1:0] rom_addr_o;
    logic [DATA_W-1:0] rom_data_i;

    logic              if_valid_o;
    logic [PC_W-1:0]   if_pc_o;
    logic [DATA_W-1:0] if_inst_o;

    modport master (
        input  stall_i,
        input  branch_i,
        input  branch_target_i,
        input  rom_data_i,
        output rom_ce_o,
        output rom_addr_o,
        output if_valid_o,
        output if_pc_o,
        output if_inst_o
    );

    modport slave (
        output stall_i,
        output branch_i,
        output branch_target_i,
        output rom_data_i,
        input  rom_ce_o,
        input  rom_addr_o,
        input  if_valid_o,
        input  if_pc_o,
        input  if_inst_o
    );

endinterface : inst_fetch_if

// File: rtl/inst_fetch_skid.sv
// One-entry skid buffer that keeps the ROM response whose presentation
// was refused by a decode stall, since the ROM output is not held.
module fetch_skid
    import cpu_defs::*;
#(
    parameter int PC_W_P   = cpu_defs::PC_W,
    parameter int DATA_W_P = cpu_defs::DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                capture_i,
    input  logic                drain_i,
    input  logic                flush_i,
    input  logic [PC_W_P-1:0]   pc_i,
    input  logic [DATA_W_P-1:0] inst_i,
    output logic                full_o,
    output logic [PC_W_P-1:0]   pc_o,
    output logic [DATA_W_P-1:0] inst_o
);

    logic                full_q;
    logic [PC_W_P-1:0]   pc_q;
    logic [DATA_W_P-1:0] inst_q;

    // Flush (redirect) outranks a capture in the same cycle so a wrong-path
    // response can never land in the buffer.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            full_q <= 1'b0;
        end else if (capture_i) begin
            full_q <= 1'b1;
        end else if (drain_i) begin
            full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= '0;
            inst_q <= DATA_W_P'(NOP_INST);
        end else if (capture_i && !flush_i) begin
            pc_q   <= pc_i;
            inst_q <= inst_i;
        end
    end

    assign full_o = full_q;
    assign pc_o   = pc_q;
    assign inst_o = inst_q;

endmodule : fetch_skid

// File: rtl/inst_fetch.sv
// Instruction-fetch initiator: owns the PC, issues ROM reads, tags the
// one-cycle-late response and presents it to decode through a skid buffer.
module inst_fetch
    import cpu_defs::*;
#(
    parameter int                ROM_AW_P   = cpu_defs::ROM_AW,
    parameter int                DATA_W_P   = cpu_defs::DATA_W,
    parameter int                PC_W_P     = cpu_defs::PC_W,
    parameter logic [PC_W_P-1:0] RESET_PC_P = PC_W_P'(cpu_defs::RESET_PC)
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  bus
);

    fetch_state_e        state_q;
    logic [PC_W_P-1:0]   fetch_pc_q;
    logic [PC_W_P-1:0]   fetch_pc_d;
    logic                resp_valid_q;
    logic [PC_W_P-1:0]   resp_pc_q;

    logic                skid_full;
    logic [PC_W_P-1:0]   skid_pc;
    logic [DATA_W_P-1:0] skid_inst;

    logic                issue;
    logic                skid_capture;
    logic                skid_drain;
    logic [1:0]          unused_target_lsbs;

    // Branch suppresses issue so the redirect target is fetched on the
    // following cycle from the updated PC.
    assign issue = (state_q == FETCH_RUN) && !rst && !bus.stall_i
                   && !skid_full && !bus.branch_i;

    assign skid_capture = resp_valid_q && bus.stall_i && !skid_full;
    assign skid_drain   = skid_full && !bus.stall_i;

    // Low target bits are dropped: fetch addresses are always word aligned.
    assign unused_target_lsbs = bus.branch_target_i[1:0];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (bus.branch_i) begin
            fetch_pc_d = {bus.branch_target_i[PC_W_P-1:2], 2'b00};
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + PC_W_P'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH_WAIT;
            fetch_pc_q   <= RESET_PC_P;
            resp_valid_q <= 1'b0;
            resp_pc_q    <= '0;
        end else begin
            case (state_q)
                FETCH_WAIT: state_q <= FETCH_RUN;
                FETCH_RUN:  state_q <= FETCH_RUN;
                default:    state_q <= FETCH_WAIT;
            endcase
            fetch_pc_q   <= fetch_pc_d;
            resp_valid_q <= issue;
            if (issue) begin
                resp_pc_q <= fetch_pc_q;
            end
        end
    end

    fetch_skid #(
        .PC_W_P   (PC_W_P),
        .DATA_W_P (DATA_W_P)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .capture_i (skid_capture),
        .drain_i   (skid_drain),
        .flush_i   (bus.branch_i),
        .pc_i      (resp_pc_q),
        .inst_i    (bus.rom_data_i),
        .full_o    (skid_full),
        .pc_o      (skid_pc),
        .inst_o    (skid_inst)
    );

    assign bus.rom_ce_o   = issue;
    assign bus.rom_addr_o = fetch_pc_q[ROM_AW_P+1:2];

    // Skid contents take precedence; an idle slot is presented as a NOP at PC 0.
    always_comb begin
        bus.if_valid_o = 1'b0;
        bus.if_pc_o    = '0;
        bus.if_inst_o  = DATA_W_P'(NOP_INST);
        if (skid_full) begin
            bus.if_valid_o = 1'b1;
            bus.if_pc_o    = skid_pc;
            bus.if_inst_o  = skid_inst;
        end else if (resp_valid_q) begin
            bus.if_valid_o = 1'b1;
            bus.if_pc_o    = resp_pc_q;
            bus.if_inst_o  = bus.rom_data_i;
        end
    end

endmodule : inst_fetch

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: reset release, stall/skid, branch, branch
// into a full skid, ROM address wrap and mid-stream reset.
module tb_inst_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    inst_fetch_if #(.ROM_AW(10), .DATA_W(32), .PC_W(32)) bus ();

    inst_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ROM model: mem[i] = 0x1000_0000 + i, one cycle after ce.
    always @(posedge clk) begin
        if (bus.rom_ce_o) begin
            bus.rom_data_i <= 32'h1000_0000 + {22'd0, bus.rom_addr_o};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, ".valid"}, {31'd0, bus.if_valid_o}, {31'd0, v});
        chk({tag, ".pc"}, bus.if_pc_o, pc);
        chk({tag, ".inst"}, bus.if_inst_o, inst);
        $display("[TB] %s valid=%0b pc=%h inst=%h ce=%0b addr=%h", tag,
                 bus.if_valid_o, bus.if_pc_o, bus.if_inst_o, bus.rom_ce_o, bus.rom_addr_o);
    endtask

    task automatic chk_rom(input string tag, input logic ce, input logic [9:0] addr);
        chk({tag, ".ce"}, {31'd0, bus.rom_ce_o}, {31'd0, ce});
        if (ce) chk({tag, ".addr"}, {22'd0, bus.rom_addr_o}, {22'd0, addr});
    endtask

    // Advance one edge; inputs are then changed at +1 and outputs sampled at +2.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic reset_release(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        settle();
        chk_rom("rel.c0", 1'b0, 10'h000);
        chk_out("rel.c0", 1'b0, 32'h0, 32'h0);
        tick(); settle();
        chk_rom("rel.c1", 1'b1, 10'h000);
        chk_out("rel.c1", 1'b0, 32'h0, 32'h0);
        tick(); settle();
        chk_out("rel.c2", 1'b1, 32'h0, 32'h1000_0000);
        chk_rom("rel.c2", 1'b1, 10'h001);
        tick(); settle();
        chk_out("rel.c3", 1'b1, 32'h4, 32'h1000_0001);
    endtask

    initial begin
        bus.stall_i         = 1'b0;
        bus.branch_i        = 1'b0;
        bus.branch_target_i = 32'h0;

        // Reset state
        rst = 1'b1;
        tick(); tick(); settle();
        chk_out("rst", 1'b0, 32'h0, 32'h0);
        chk_rom("rst", 1'b0, 10'h000);
        chk("rst.addr", {22'd0, bus.rom_addr_o}, 32'h0);

        // Reset release and stall
        reset_release(1);
        tick(); bus.stall_i = 1'b1; settle();
        chk_out("stall.c4", 1'b1, 32'h8, 32'h1000_0002);
        chk_rom("stall.c4", 1'b0, 10'h000);
        tick(); settle();
        chk_out("stall.c5", 1'b1, 32'h8, 32'h1000_0002);
        tick(); settle();
        chk_out("stall.c6", 1'b1, 32'h8, 32'h1000_0002);
        chk_rom("stall.c6", 1'b0, 10'h000);
        tick(); bus.stall_i = 1'b0; settle();
        chk_out("stall.rel", 1'b1, 32'h8, 32'h1000_0002);
        chk_rom("stall.rel", 1'b0, 10'h000);
        tick(); settle();
        chk_out("stall.bubble", 1'b0, 32'h0, 32'h0);
        chk_rom("stall.bubble", 1'b1, 10'h003);
        tick(); settle();
        chk_out("stall.pcC", 1'b1, 32'hC, 32'h1000_0003);
        tick(); settle();
        chk_out("stall.pc10", 1'b1, 32'h10, 32'h1000_0004);

        // Branch while pc 0x4 is presented
        reset_release(2);
        bus.branch_i = 1'b1; bus.branch_target_i = 32'h40; settle();
        chk_rom("br.c3", 1'b0, 10'h000);
        tick(); bus.branch_i = 1'b0; settle();
        chk_out("br.c4", 1'b0, 32'h0, 32'h0);
        chk_rom("br.c4", 1'b1, 10'h010);
        tick(); settle();
        chk_out("br.c5", 1'b1, 32'h40, 32'h1000_0010);
        tick(); settle();
        chk_out("br.c6", 1'b1, 32'h44, 32'h1000_0011);

        // Branch with a full skid and misaligned target
        reset_release(1);
        tick(); bus.stall_i = 1'b1; settle();
        chk_out("bsk.c4", 1'b1, 32'h8, 32'h1000_0002);
        tick(); bus.branch_i = 1'b1; bus.branch_target_i = 32'h43; settle();
        chk_out("bsk.c5", 1'b1, 32'h8, 32'h1000_0002);
        tick(); bus.branch_i = 1'b0; bus.stall_i = 1'b0; settle();
        chk_out("bsk.c6", 1'b0, 32'h0, 32'h0);
        chk_rom("bsk.c6", 1'b1, 10'h010);
        tick(); settle();
        chk_out("bsk.c7", 1'b1, 32'h40, 32'h1000_0010);

        // Wrap of the ROM word address
        bus.branch_i = 1'b1; bus.branch_target_i = 32'hFFC; settle();
        tick(); bus.branch_i = 1'b0; settle();
        chk_rom("wrap.a", 1'b1, 10'h3FF);
        tick(); settle();
        chk_out("wrap.ffc", 1'b1, 32'hFFC, 32'h1000_03FF);
        chk_rom("wrap.b", 1'b1, 10'h000);
        tick(); settle();
        chk_out("wrap.1000", 1'b1, 32'h1000, 32'h1000_0000);

        // Reset while the skid is full
        bus.stall_i = 1'b1; settle();
        tick(); settle();
        chk_out("mrst.skid", 1'b1, 32'h1000, 32'h1000_0000);
        bus.stall_i = 1'b0;
        reset_release(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_inst_fetch
